// File: rtl/stream_mux_rr.sv
// N-channel round-robin stream mux with one registered output stage (1-cycle latency, full throughput).
// Optional packet lock (define STREAM_MUX_LAST_LOCK_EN): a channel holds the grant until its in_last beat.
module stream_mux_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  localparam int CW   = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [CW-1:0]        out_chan
);

  logic              r_out_valid;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_last;
  logic [CW-1:0]     r_out_chan;
  logic [CW-1:0]     r_ptr;

  logic [2*N-1:0]    w_rot_src;
  logic [N-1:0]      w_rot;
  logic [CW-1:0]     w_off;
  logic              w_found;
  logic [CW:0]       w_sum;
  logic [CW-1:0]     w_rr_grant;
  logic [CW-1:0]     w_grant;
  logic              w_gnt_vld;
  logic              w_load;
  logic              w_take;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_sel_last;

  // Rotate the request vector so bit 0 is the channel at r_ptr, then find the first requester.
  always_comb begin
    w_rot_src = {in_valid, in_valid};
    w_rot     = w_rot_src[r_ptr +: N];
    w_off     = '0;
    w_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = CW'(k);
      end
    end
    w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
    w_rr_grant = (w_sum >= (CW+1)'(N)) ? CW'(w_sum - (CW+1)'(N)) : CW'(w_sum);
  end

`ifdef STREAM_MUX_LAST_LOCK_EN
  logic          r_lock;
  logic [CW-1:0] r_lock_chan;

  always_comb begin
    if (r_lock) begin
      w_grant   = r_lock_chan;
      w_gnt_vld = in_valid[r_lock_chan];
    end else begin
      w_grant   = w_rr_grant;
      w_gnt_vld = w_found;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock      <= 1'b0;
      r_lock_chan <= '0;
    end else if (w_take) begin
      r_lock <= ~w_sel_last;
      if (!w_sel_last) r_lock_chan <= w_grant;
    end
  end
`else
  assign w_grant   = w_rr_grant;
  assign w_gnt_vld = w_found;
`endif

  assign w_load = ~r_out_valid | out_ready;
  assign w_take = w_load & w_gnt_vld;

  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == CW'(i)) begin
        w_sel_data = in_data[i*WIDTH +: WIDTH];
        w_sel_last = in_last[i];
      end
    end
  end

  // in_ready depends only on valids and output state, never on data or last.
  always_comb begin
    in_ready = '0;
    if (!rst && w_take) in_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_last  <= w_sel_last;
      r_out_chan  <= w_grant;
      r_ptr       <= (w_grant == CW'(N-1)) ? '0 : w_grant + 1'b1;
    end else if (w_load) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scenario bench for stream_mux_rr (N=4, WIDTH=8) with a queue of expected output beats.
module tb_stream_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [1:0]   out_chan;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] chan;
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  stream_mux_rr #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_chan(out_chan)
  );

  task automatic set_ch(input int ch, input logic [7:0] d, input logic l);
    in_data[ch*W +: W] = d;
    in_last[ch] = l;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '1; in_data = 32'hDEADBEEF; in_last = '1; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL reset_out_chan got=%0d exp=0", out_chan); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", out_last); end
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    end
    in_valid = '0; in_last = '0; rst = 1'b0; exp_q.delete();
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_single();
    beat_t e;
    out_ready = 1'b1;
    set_ch(2, 8'hA5, 1'b1); in_valid = 4'b0100; #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL single_in_ready got=%b exp=0100", in_ready); end
    exp_q.push_back('{2'd2, 8'hA5, 1'b1});
    @(posedge clk); #1;
    in_valid = '0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL single_underflow queue empty"); end
    else begin
      e = exp_q.pop_front(); checks++;
      if ({out_chan, out_data, out_last} !== e) begin failures++;
        $display("FAIL single_beat got ch=%0d d=%h l=%b exp ch=%0d d=%h l=%b", out_chan, out_data, out_last, e.chan, e.data, e.last); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_round_robin();
    beat_t e;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    out_ready = 1'b1;
    for (int ch = 0; ch < N; ch++) set_ch(ch, 8'h10 + 8'(ch), 1'b1);
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back('{2'(k % N), 8'h10 + 8'(k % N), 1'b1});
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) in_valid = '0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_bubble cycle=%0d got=%b exp=1", k, out_valid); end
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL rr_underflow cycle=%0d", k); end
      else begin
        e = exp_q.pop_front(); checks++;
        if ({out_chan, out_data, out_last} !== e) begin failures++;
          $display("FAIL rr_beat cycle=%0d got ch=%0d d=%h exp ch=%0d d=%h", k, out_chan, out_data, e.chan, e.data); end
      end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    beat_t e;
    out_ready = 1'b0;
    set_ch(1, 8'h3C, 1'b1); in_valid = 4'b0010; #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_first_ready got=%b exp=0010", in_ready); end
    exp_q.push_back('{2'd1, 8'h3C, 1'b1});
    @(posedge clk); #1;
    set_ch(1, 8'h3D, 1'b1); #1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cycle=%0d got=%b exp=1", c, out_valid); end
      checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL bp_hold_data cycle=%0d got=%h exp=3c", c, out_data); end
      checks++; if (out_chan !== 2'd1) begin failures++; $display("FAIL bp_hold_chan cycle=%0d got=%0d exp=1", c, out_chan); end
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_stall_ready cycle=%0d got=%b exp=0000", c, in_ready); end
      if (c < 2) begin @(posedge clk); #1; end
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL bp_pop_push_ready got=%b exp=0010", in_ready); end
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL bp_underflow first"); end
    else begin
      e = exp_q.pop_front(); checks++;
      if ({out_chan, out_data, out_last} !== e) begin failures++;
        $display("FAIL bp_beat_3c got ch=%0d d=%h exp ch=%0d d=%h", out_chan, out_data, e.chan, e.data); end
    end
    exp_q.push_back('{2'd1, 8'h3D, 1'b1});
    @(posedge clk); #1;
    in_valid = '0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_continuous got=%b exp=1", out_valid); end
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL bp_underflow second"); end
    else begin
      e = exp_q.pop_front(); checks++;
      if ({out_chan, out_data, out_last} !== e) begin failures++;
        $display("FAIL bp_beat_3d got ch=%0d d=%h exp ch=%0d d=%h", out_chan, out_data, e.chan, e.data); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_skip_wrap();
    beat_t e;
    out_ready = 1'b1;
    set_ch(2, 8'h22, 1'b1); in_valid = 4'b0100;
    exp_q.push_back('{2'd2, 8'h22, 1'b1});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL wrap_underflow ch2"); end
    else begin
      e = exp_q.pop_front(); checks++;
      if ({out_chan, out_data, out_last} !== e) begin failures++;
        $display("FAIL wrap_setup got ch=%0d d=%h exp ch=%0d d=%h", out_chan, out_data, e.chan, e.data); end
    end
    set_ch(0, 8'h30, 1'b1); set_ch(1, 8'h31, 1'b1); in_valid = 4'b0011; #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL wrap_grant0 got=%b exp=0001", in_ready); end
    exp_q.push_back('{2'd0, 8'h30, 1'b1});
    @(posedge clk); #1;
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL wrap_underflow ch0"); end
    else begin
      e = exp_q.pop_front(); checks++;
      if ({out_chan, out_data, out_last} !== e) begin failures++;
        $display("FAIL wrap_beat0 got ch=%0d d=%h exp ch=%0d d=%h", out_chan, out_data, e.chan, e.data); end
    end
    checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL wrap_grant1 got=%b exp=0010", in_ready); end
    exp_q.push_back('{2'd1, 8'h31, 1'b1});
    @(posedge clk); #1;
    in_valid = '0;
    if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL wrap_underflow ch1"); end
    else begin
      e = exp_q.pop_front(); checks++;
      if ({out_chan, out_data, out_last} !== e) begin failures++;
        $display("FAIL wrap_beat1 got ch=%0d d=%h exp ch=%0d d=%h", out_chan, out_data, e.chan, e.data); end
    end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_lock();
    beat_t e;
    int c0;
    int c1;
    logic [N-1:0] rdy;
    c0 = 0; c1 = 0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    out_ready = 1'b1; in_valid = '0; in_last = '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
    exp_q.push_back('{2'd0, 8'hA0, 1'b0});
    exp_q.push_back('{2'd0, 8'hA1, 1'b0});
    exp_q.push_back('{2'd0, 8'hA2, 1'b1});
    exp_q.push_back('{2'd1, 8'hB0, 1'b1});
`else
    exp_q.push_back('{2'd0, 8'hA0, 1'b0});
    exp_q.push_back('{2'd1, 8'hB0, 1'b1});
    exp_q.push_back('{2'd0, 8'hA1, 1'b0});
    exp_q.push_back('{2'd1, 8'hB1, 1'b1});
`endif
    for (int k = 0; k < 4; k++) begin
      set_ch(0, 8'hA0 + 8'(c0), (c0 == 2));
      set_ch(1, 8'hB0 + 8'(c1), 1'b1);
      in_valid = {2'b00, 1'b1, (c0 < 3)};
      #1;
      rdy = in_ready;
      @(posedge clk);
      if (rdy[0]) c0++;
      if (rdy[1]) c1++;
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL lock_valid beat=%0d got=%b exp=1", k, out_valid); end
      if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL lock_underflow beat=%0d", k); end
      else begin
        e = exp_q.pop_front(); checks++;
        if ({out_chan, out_data, out_last} !== e) begin failures++;
          $display("FAIL lock_beat beat=%0d got ch=%0d d=%h l=%b exp ch=%0d d=%h l=%b", k, out_chan, out_data, out_last, e.chan, e.data, e.last); end
      end
    end
    in_valid = '0;
    @(posedge clk); #1;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lock_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_skip_wrap();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshake on every channel and on the output.
- Round-robin arbitration replaces the static select input of earlier mux blocks.
- Single registered output stage: 1-cycle latency, full throughput of one beat per cycle.
- Sits between multiple producer streams and one shared consumer, such as a shared display or audio sink.

Parameters:
- N, 4, number of input channels; legal range 2..16.
- WIDTH, 8, data bits per channel.
- CW, $clog2(N), channel index width (derived localparam, not overridable).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  N  bit i: channel i presents a beat.
- in_ready  output  N  bit i: channel i beat is accepted this cycle.
- in_data  input  N*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  N  bit i: end-of-packet marker for channel i.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered last flag.
- out_chan  output  CW  index of the channel that sourced the current beat.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out_data=0, out_last=0, out_chan=0, ptr=0, lock=0. rst overrides all other activity, including a transfer in the same cycle.
- in_ready is combinational and is 0 for all bits while rst=1.
- load_en = ~out_valid | out_ready. The output register may accept a new beat when empty or when its current beat is being consumed.
- Arbitration (combinational):
  - grant = first channel i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - any_valid = |in_valid.
- in_ready[i] = load_en & any_valid & (grant==i). At most one bit is high.
- in_ready must not depend on in_data or in_last. It may depend on in_valid.
- On a clock edge with load_en & any_valid:
  - out_data <= in_data[grant], out_last <= in_last[grant], out_chan <= grant, out_valid <= 1.
  - ptr <= (grant==N-1) ? 0 : grant+1.
- On a clock edge with load_en & ~any_valid: out_valid <= 0. out_data, out_last, out_chan and ptr hold.
- On a clock edge with out_valid & ~out_ready: all output registers and ptr hold. in_ready is all zeros.
- Latency: a beat accepted at edge k is visible on the outputs after edge k.
- Back-to-back: with out_ready=1 held high, one beat transfers every cycle with no bubble.
- Fairness: with all N channels continuously valid, grants rotate 0,1,...,N-1,0,... Each channel waits at most N-1 grants.
- Input beats are never dropped or duplicated. A channel beat leaves only when in_valid[i] & in_ready[i].
- Simultaneous pop and push: a consumer pop and a new load in the same cycle is legal and yields a continuous out_valid=1.

Optional Feature:
- Macro: STREAM_MUX_LAST_LOCK_EN.
- Defined (packet lock):
  - Loading a beat with in_last[grant]=0 sets lock=1 and lock_chan=grant.
  - While lock=1, grant=lock_chan if in_valid[lock_chan]=1, else no grant. Other channels stall even if valid.
  - Loading a beat from lock_chan with in_last=1 clears lock. ptr then advances from lock_chan+1 as normal.
  - Reset clears lock mid-packet.
- Not defined: in_last is only forwarded to out_last. Arbitration is per beat and packets from different channels may interleave.

Test Plan:
- Reset: rst=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0.
- Single channel: N=4, WIDTH=8, only ch2 valid with data 8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=A5, out_chan=2.
- Round robin: all 4 channels valid with data 8'h10/11/12/13 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, data 10,11,12,13,10, no bubbles.
- Backpressure:
  - Ch1 valid 8'h3C, out_ready=0 for 3 cycles -> out_data stays 3C, out_chan=1, in_ready=0 while stalled.
  - Ch1 then presents 8'h3D and out_ready=1 -> 3D loads on the same edge that 3C is consumed.
- Skip and wrap: ptr=3 (after a grant to ch2), only ch0 and ch1 valid -> grant ch0, then ch1. Verifies wrap-around from N-1 to 0.
- Lock (macro defined):
  - Ch0 sends a 3-beat packet (last on beat 3) while ch1 is continuously valid -> output shows ch0,ch0,ch0 then ch1.
  - Without the macro, the same stimulus interleaves ch0,ch1,ch0,ch1.
